// File: rtl/darkarb_pkg.sv
// Shared types and constants for the darkarb two-requester ROM arbiter.
package darkarb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef logic [0:0] req_idx_t;

  localparam req_idx_t    REQ_M0 = 1'b0;
  localparam req_idx_t    REQ_M1 = 1'b1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

endpackage

// File: rtl/darkbus.sv
// Simple request/response read bus: prod issues addr/en, cons returns data/valid.
interface darkbus;
  logic [31:0] addr;
  logic [31:0] data;
  logic        en;
  logic        valid;

  modport prod (output addr, output en, input data, input valid);
  modport cons (input addr, input en, output data, output valid);
endinterface

// File: rtl/darkarb_pick.sv
// Grant selection for darkarb: winner, last-granted index and, with DARKARB_RR_EN,
// the round-robin pointer and burst limiter; otherwise fixed priority to M0.
module darkarb_pick
  import darkarb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic     xclk,
  input  logic     xres,
  input  logic     en0,
  input  logic     en1,
  output logic     gnt_v,
  output req_idx_t gnt_idx,
  output req_idx_t last_idx
);

  assign gnt_v = (en0 | en1) & ~xres;

  always_ff @(posedge xclk) begin
    if (xres)
      last_idx <= REQ_M0;
    else if (gnt_v)
      last_idx <= gnt_idx;
  end

`ifdef DARKARB_RR_EN
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  req_idx_t   ptr;
  logic [3:0] burst;
  logic       both;

  assign both = en0 & en1;

  // A requester at its burst limit yields to a waiting peer before the pointer is consulted.
  always_comb begin
    gnt_idx = ptr;
    if (!both)
      gnt_idx = en0 ? REQ_M0 : REQ_M1;
    else if (burst >= BURST_LIM)
      gnt_idx = ~last_idx;
  end

  always_ff @(posedge xclk) begin
    if (xres) begin
      ptr   <= REQ_M0;
      burst <= 4'd0;
    end else if (gnt_v) begin
      if (gnt_idx != last_idx)
        burst <= 4'd1;
      else if (burst < BURST_LIM)
        burst <= burst + 4'd1;
      if (both)
        ptr <= ~gnt_idx;
    end
  end
`else
  assign gnt_idx = en0 ? REQ_M0 : REQ_M1;
`endif

endmodule

// File: rtl/darkarb.sv
// Arbitrates instruction-fetch (M0) and data-read (M1) requesters onto one ROM port.
// Round-robin with burst limit when DARKARB_RR_EN is defined, fixed M0 priority otherwise.
//
// state    | meaning
// ARB_IDLE | no grant last cycle, no response pending
// ARB_BUSY | granted last cycle, ROM response due this cycle
module darkarb
  import darkarb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input logic  XCLK,
  input logic  XRES,
  darkbus.cons M0,
  darkbus.cons M1,
  darkbus.prod S
);

  logic       gnt_v;
  req_idx_t   gnt_idx;
  req_idx_t   resp_sel;
  arb_state_t state;
  logic       resp_p;
  logic       hit0;
  logic       hit1;

  darkarb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .xclk     (XCLK),
    .xres     (XRES),
    .en0      (M0.en),
    .en1      (M1.en),
    .gnt_v    (gnt_v),
    .gnt_idx  (gnt_idx),
    .last_idx (resp_sel)
  );

  assign S.en   = gnt_v;
  assign S.addr = !gnt_v ? 32'h0 : ((gnt_idx == REQ_M1) ? M1.addr : M0.addr);

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: if (gnt_v)  state <= ARB_BUSY;
        ARB_BUSY: if (!gnt_v) state <= ARB_IDLE;
      endcase
    end
  end

  // Gating with XRES drops a response that was in flight when reset arrived.
  assign resp_p = (state == ARB_BUSY) & ~XRES;
  assign hit0   = resp_p & (resp_sel == REQ_M0);
  assign hit1   = resp_p & (resp_sel == REQ_M1);

  assign M0.valid = hit0 & S.valid;
  assign M0.data  = hit0 ? S.data : NOP;
  assign M1.valid = hit1 & S.valid;
  assign M1.data  = hit1 ? S.data : NOP;

endmodule
